// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared state encoding and width helper for the UART TX scheduler
package uart_sched_pkg;
    typedef enum logic [1:0] {IDLE, SEND, LOCK} state_t;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// rr_pick: combinational round-robin pick, first set bit searching upward from ptr_i+1
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    always_comb begin
        grant_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % N]) begin
                any_o = 1'b1;
                idx_o = W'((int'(ptr_i) + k) % N);
                grant_o[(int'(ptr_i) + k) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: message-granular round-robin sharing of one UART data-register port
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LOCK_TIMEOUT = 1024,
    localparam int ID_W = id_w(N_REQ)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]  req_last,
    output logic [N_REQ-1:0]  req_ready,
    output logic              uart_dat_we,
    output logic [7:0]        uart_dat_di,
    input  logic              uart_dat_ack,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy,
    output logic              lock_timeout
);
    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic              hold_last_q, hold_last_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d, ptr_q, ptr_d, pick_idx, sel;
    logic [TW-1:0]     timer_q, timer_d;
    logic              lock_timeout_q, lock_timeout_d;
    logic [N_REQ-1:0]  pick_grant;
    logic              pick_any, cap, release_msg, tmo;

    rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (
        .req_i(req_valid),
        .ptr_i(ptr_q),
        .grant_o(pick_grant),
        .idx_o(pick_idx),
        .any_o(pick_any)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            grant_id_q <= '0;
            ptr_q <= ID_W'(N_REQ - 1);
            timer_q <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            grant_id_q <= grant_id_d;
            ptr_q <= ptr_d;
            timer_q <= timer_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = pick_any ? SEND : IDLE;
            SEND: state_d = !uart_dat_ack ? SEND : hold_last_q ? IDLE : LOCK;
            LOCK: state_d = cap ? SEND : tmo ? IDLE : LOCK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) ? pick_grant :
                    (state_q == LOCK) ? req_valid & (N_REQ'(1) << grant_id_q) : '0;
        uart_dat_we = state_q == SEND;
    end

    // A capture in the final LOCK cycle beats the timeout
    assign cap = |req_ready;
    assign sel = (state_q == IDLE) ? pick_idx : grant_id_q;
    assign tmo = (LOCK_TIMEOUT != 0) && state_q == LOCK && !cap && timer_q == T_LAST;
    assign release_msg = state_q == SEND && uart_dat_ack && hold_last_q;

    always_comb begin
        hold_data_d = cap ? req_data[8*sel +: 8] : hold_data_q;
        hold_last_d = cap ? req_last[sel] : hold_last_q;
        grant_id_d = cap ? sel : grant_id_q;
        ptr_d = (release_msg || tmo) ? grant_id_q : ptr_q;
        timer_d = (state_q == SEND) ? '0 :
                  (state_q == LOCK && timer_q != '1) ? timer_q + 1'b1 : timer_q;
        lock_timeout_d = tmo;
    end

    assign uart_dat_di = hold_data_q;
    assign grant_id = grant_id_q;
    assign busy = state_q != IDLE;
    assign lock_timeout = lock_timeout_q;
endmodule
